alu_issue_stage: RTL
====================

# alu_issue_stage

Registered issue stage that produces every input the RV32I ALU consumes. It decodes a 32-bit instruction into the 4-bit ALU control code, selects and registers operand A and operand B, and holds them in the ID/EX boundary with a valid/ready handshake, stall and flush. It sits between the decode/register-file read stage and the ALU, on the driving side of the ALU's `operand_a` / `operand_b` / `alu_control` interface.

## Interface
- `DATA_WIDTH`, 32 — operand and PC width.
- `clk` input 1 — sole clock; all state updates on rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `in_valid` input 1 — upstream presents an instruction.
- `in_ready` output 1 — stage accepts this cycle.
- `in_instr` input 32 — raw instruction word.
- `in_pc` input DATA_WIDTH — PC of the instruction.
- `in_rs1_data`, `in_rs2_data` input DATA_WIDTH — register-file read values.
- `flush` input 1 — discard held and incoming instruction.
- `out_valid` output 1 — registered bundle valid.
- `out_ready` input 1 — ALU/EX stage consumes the bundle.
- `out_operand_a`, `out_operand_b` output DATA_WIDTH — ALU operands.
- `out_alu_control` output 4 — ALU code: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SLL 1000, SRL 1001, SRA 1010, XOR 1100, SLTU 1101.
- `out_rd` output 5; `out_reg_write` output 1; `out_is_branch` output 1; `out_funct3` output 3; `out_illegal` output 1.

## Operation
- `in_ready = !flush && (!out_valid || out_ready)`. A transfer occurs when `in_valid && in_ready`.
- Decode by opcode `in_instr[6:0]`:
  - 0110011 (R-type), by funct3:
    - 000 → ADD, or SUB when funct7 = 0100000.
    - 001 → SLL; 010 → SLT; 011 → SLTU; 100 → XOR.
    - 101 → SRL, or SRA when funct7 = 0100000.
    - 110 → OR; 111 → AND.
    - A = rs1, B = rs2.
    - Legal funct7 is 0000000 only, plus 0100000 for funct3 000/101; anything else is illegal.
  - 0010011 (I-type ALU): same funct3 map; B = sign-extended `instr[31:20]`.
    - funct3 000 is always ADD.
    - Shifts: B = `{27'b0, instr[24:20]}`; `instr[31:25]` must be 0000000, or 0100000 for SRAI; otherwise illegal.
  - 0000011 (load) / 0100011 (store): ADD, A = rs1, B = sign-extended I-imm or S-imm `{instr[31:25], instr[11:7]}`.
  - 1100011 (branch): A = rs1, B = rs2, `out_is_branch` = 1, `out_reg_write` = 0.
    - funct3 000/001 → SUB; 100/101 → SLT; 110/111 → SLTU; 010/011 → illegal.
  - 0110111 (LUI): ADD, A = 0, B = `{instr[31:12], 12'b0}`.
  - 0010111 (AUIPC): ADD, A = pc, B = U-imm.
  - 1101111 (JAL) / 1100111 (JALR): ADD, A = pc, B = 4 (link value).
  - Any other opcode: illegal.
- `out_reg_write` = 1 for R, I, load, LUI, AUIPC, JAL, JALR — but only when `rd` ≠ 0 and the instruction is legal.
- Illegal instruction: `out_alu_control` = ADD, `out_reg_write` = 0, `out_is_branch` = 0, `out_illegal` = 1. The bundle still goes valid so the trap logic sees it.
- `out_funct3` and `out_rd` pass through unmodified.

## Timing
- Reset: `out_valid` = 0, all data outputs 0, `out_alu_control` = 0010 (ADD), `out_illegal` = 0. `in_ready` = 0 while `flush` is high, otherwise 1.
- Latency: one cycle from transfer to `out_valid`. Back-to-back throughput is one per cycle when `out_ready` = 1.
- Stall (`out_valid && !out_ready`): every output holds bit-stable; `in_ready` = 0.
- Flush: clears `out_valid` next cycle and takes priority over load and stall. Incoming data is not captured; data registers may hold stale values.
- Reset asserted mid-stall or concurrently with flush: reset wins; outputs take reset values next edge.
- When `out_valid` = 0, data outputs are don't-care except `out_reg_write` = 0.

## Structure
- Shared `riscv_pkg`:
  - `alu_op_e` enum with the ten codes above.
  - Opcode constants (`OPC_OP`, `OPC_OP_IMM`, `OPC_LOAD`, `OPC_STORE`, `OPC_BRANCH`, `OPC_LUI`, `OPC_AUIPC`, `OPC_JAL`, `OPC_JALR`).
  - funct7 constants `F7_BASE` = 0000000, `F7_ALT` = 0100000.
- Sub-module `alu_ctrl_decode`: purely combinational instruction → {control, operand selects, immediate, illegal, reg_write, is_branch}.
- The top level holds the handshake and output registers only.

## Test plan
- ADD then SUB: `add x3,x1,x2` (0x002081B3), rs1 = 5, rs2 = 7 → next cycle `out_valid` = 1, A = 5, B = 7, control 0010, rd = 3, reg_write = 1. `sub` (0x402081B3) → control 0110.
- SRAI: 0x4030D193 (`srai x3,x1,3`), rs1 = 0x80000000 → control 1010, B = 3. With `instr[31:25]` = 0100001 → `out_illegal` = 1, reg_write = 0, control 0010.
- BLTU: 0x0020E463, rs1 = 1, rs2 = 2 → control 1101, is_branch = 1, reg_write = 0. AUIPC 0x12345197 at pc 0x100 → A = 0x100, B = 0x12345000.
- Stall: `out_ready` = 0 for 3 cycles with a new `in_valid` → `in_ready` = 0, outputs unchanged. Release → the held bundle retires, then the queued instruction appears the following cycle.
- Flush: `flush` = 1 together with `in_valid` and a held valid bundle → `out_valid` = 0 next cycle, no capture. Check the same with `rst` = 1 during a stall → all outputs at reset values.
- Random legal/illegal words (10k) checked against a reference decoder model; assert no `out_reg_write` with rd = 0.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared RV32I opcode, funct7 and ALU control definitions.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SLL  = 4'b1000,
        ALU_SRL  = 4'b1001,
        ALU_SRA  = 4'b1010,
        ALU_XOR  = 4'b1100,
        ALU_SLTU = 4'b1101
    } alu_op_e;

    typedef enum logic [1:0] {
        A_SEL_RS1  = 2'd0,
        A_SEL_PC   = 2'd1,
        A_SEL_ZERO = 2'd2
    } a_sel_e;

    typedef enum logic {
        B_SEL_RS2 = 1'b0,
        B_SEL_IMM = 1'b1
    } b_sel_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Base funct3 mapping shared by register and immediate ALU forms.
    function automatic alu_op_e f3_to_op(input logic [2:0] funct3);
        alu_op_e op;
        case (funct3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_decode
//  Description : Combinational RV32I decode to ALU control, operand selects,
//                immediate and legality/writeback/branch flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_decode
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    output alu_op_e     alu_control,
    output a_sel_e      a_sel,
    output b_sel_e      b_sel,
    output logic [31:0] imm,
    output logic        illegal,
    output logic        reg_write,
    output logic        is_branch
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic [4:0] w_rd;
    alu_op_e    w_op;
    logic       w_illegal;
    logic       w_writes;
    logic       w_branch;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];
    assign w_rd     = instr[11:7];

    always_comb begin
        w_op      = ALU_ADD;
        a_sel     = A_SEL_RS1;
        b_sel     = B_SEL_RS2;
        imm       = '0;
        w_illegal = 1'b0;
        w_writes  = 1'b0;
        w_branch  = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_writes = 1'b1;
                w_op     = f3_to_op(w_funct3);
                if (w_funct7 == F7_ALT && w_funct3 == 3'b000) begin
                    w_op = ALU_SUB;
                end else if (w_funct7 == F7_ALT && w_funct3 == 3'b101) begin
                    w_op = ALU_SRA;
                end else if (w_funct7 != F7_BASE) begin
                    w_illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                w_writes = 1'b1;
                b_sel    = B_SEL_IMM;
                w_op     = f3_to_op(w_funct3);
                imm      = {{20{instr[31]}}, instr[31:20]};
                // Shift-immediates carry a 5-bit shamt; upper bits act as funct7.
                if (w_funct3 == 3'b001) begin
                    imm = {27'b0, instr[24:20]};
                    if (w_funct7 != F7_BASE) begin
                        w_illegal = 1'b1;
                    end
                end else if (w_funct3 == 3'b101) begin
                    imm = {27'b0, instr[24:20]};
                    if (w_funct7 == F7_ALT) begin
                        w_op = ALU_SRA;
                    end else if (w_funct7 != F7_BASE) begin
                        w_illegal = 1'b1;
                    end
                end
            end
            OPC_LOAD: begin
                w_writes = 1'b1;
                b_sel    = B_SEL_IMM;
                imm      = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_STORE: begin
                b_sel = B_SEL_IMM;
                imm   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                w_branch = 1'b1;
                case (w_funct3)
                    3'b000, 3'b001: w_op = ALU_SUB;
                    3'b100, 3'b101: w_op = ALU_SLT;
                    3'b110, 3'b111: w_op = ALU_SLTU;
                    default:        w_illegal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                w_writes = 1'b1;
                a_sel    = A_SEL_ZERO;
                b_sel    = B_SEL_IMM;
                imm      = {instr[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                w_writes = 1'b1;
                a_sel    = A_SEL_PC;
                b_sel    = B_SEL_IMM;
                imm      = {instr[31:12], 12'b0};
            end
            OPC_JAL, OPC_JALR: begin
                // ALU forms the link value pc + 4.
                w_writes = 1'b1;
                a_sel    = A_SEL_PC;
                b_sel    = B_SEL_IMM;
                imm      = 32'd4;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign alu_control = w_illegal ? ALU_ADD : w_op;
    assign illegal     = w_illegal;
    assign reg_write   = w_writes && !w_illegal && (w_rd != 5'd0);
    assign is_branch   = w_branch && !w_illegal;

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_stage
//  Description : ID/EX issue register feeding the ALU operands and control
//                with valid/ready handshake, stall and flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_rs1_data,
    input  logic [DATA_WIDTH-1:0] in_rs2_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_operand_a,
    output logic [DATA_WIDTH-1:0] out_operand_b,
    output logic [3:0]            out_alu_control,
    output logic [4:0]            out_rd,
    output logic                  out_reg_write,
    output logic                  out_is_branch,
    output logic [2:0]            out_funct3,
    output logic                  out_illegal
);

    alu_op_e               w_alu_control;
    a_sel_e                w_a_sel;
    b_sel_e                w_b_sel;
    logic [31:0]           w_imm;
    logic                  w_illegal;
    logic                  w_reg_write;
    logic                  w_is_branch;
    logic [DATA_WIDTH-1:0] w_imm_ext;
    logic [DATA_WIDTH-1:0] w_operand_a;
    logic [DATA_WIDTH-1:0] w_operand_b;
    logic                  w_in_ready;
    logic                  w_load;

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_operand_a;
    logic [DATA_WIDTH-1:0] r_operand_b;
    alu_op_e               r_alu_control;
    logic [4:0]            r_rd;
    logic                  r_reg_write;
    logic                  r_is_branch;
    logic [2:0]            r_funct3;
    logic                  r_illegal;

    alu_ctrl_decode u_decode (
        .instr       (in_instr),
        .alu_control (w_alu_control),
        .a_sel       (w_a_sel),
        .b_sel       (w_b_sel),
        .imm         (w_imm),
        .illegal     (w_illegal),
        .reg_write   (w_reg_write),
        .is_branch   (w_is_branch)
    );

    assign w_imm_ext = DATA_WIDTH'($signed(w_imm));

    always_comb begin
        case (w_a_sel)
            A_SEL_PC:   w_operand_a = in_pc;
            A_SEL_ZERO: w_operand_a = '0;
            default:    w_operand_a = in_rs1_data;
        endcase
    end

    assign w_operand_b = (w_b_sel == B_SEL_IMM) ? w_imm_ext : in_rs2_data;
    assign w_in_ready  = !flush && (!r_valid || out_ready);
    assign w_load      = in_valid && w_in_ready;

    // reg_write is cleared whenever the bundle drops, so an idle stage never
    // advertises a writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid       <= 1'b0;
            r_operand_a   <= '0;
            r_operand_b   <= '0;
            r_alu_control <= ALU_ADD;
            r_rd          <= '0;
            r_reg_write   <= 1'b0;
            r_is_branch   <= 1'b0;
            r_funct3      <= '0;
            r_illegal     <= 1'b0;
        end else if (flush) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
        end else if (w_load) begin
            r_valid       <= 1'b1;
            r_operand_a   <= w_operand_a;
            r_operand_b   <= w_operand_b;
            r_alu_control <= w_alu_control;
            r_rd          <= in_instr[11:7];
            r_reg_write   <= w_reg_write;
            r_is_branch   <= w_is_branch;
            r_funct3      <= in_instr[14:12];
            r_illegal     <= w_illegal;
        end else if (out_ready) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
        end
    end

    assign in_ready        = w_in_ready;
    assign out_valid       = r_valid;
    assign out_operand_a   = r_operand_a;
    assign out_operand_b   = r_operand_b;
    assign out_alu_control = r_alu_control;
    assign out_rd          = r_rd;
    assign out_reg_write   = r_reg_write;
    assign out_is_branch   = r_is_branch;
    assign out_funct3      = r_funct3;
    assign out_illegal     = r_illegal;

endmodule
`default_nettype wire
